// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage access unit.
// FSM states, funct3 load/store codes, decode bit defaults.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } mau_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam int DEC_RE_BIT_DEF = 3;
  localparam int DEC_WE_BIT_DEF = 2;

  // funct3[1:0] is the log2 access size for loads and stores.
  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [2:0] off
  );
    logic m;
    m = 1'b0;
    unique case (f3[1:0])
      2'b01:   m = off[0];
      2'b10:   m = |off[1:0];
      2'b11:   m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus.
// master = MEM stage, slave = memory.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        rsp_valid;
  logic [63:0] rsp_data;

  modport master (
    output req_valid, we, addr, wdata, wmask,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, we, addr, wdata, wmask,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Load return alignment: shift doubleword by byte offset, extend.
// ld_buf/offset/funct3 in, data out (0 for unused funct3).
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [63:0] ld_buf,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [63:0] d;

  assign d = ld_buf >> {offset, 3'b000};

  always_comb begin
    data = '0;
    unique case (funct3)
      F3_B:    data = {{56{d[7]}}, d[7:0]};
      F3_H:    data = {{48{d[15]}}, d[15:0]};
      F3_W:    data = {{32{d[31]}}, d[31:0]};
      F3_D:    data = d;
      F3_BU:   data = {56'b0, d[7:0]};
      F3_HU:   data = {48'b0, d[15:0]};
      F3_WU:   data = {32'b0, d[31:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: EX/MEM fields -> dmem bus.
// Ports: EX/MEM fields, flush, dmem master, stall/misalign/wb.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DEC_RE_BIT = DEC_RE_BIT_DEF,
  parameter int DEC_WE_BIT = DEC_WE_BIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_ins_i,
  input  logic [21:0] mem_decode_i,
  input  logic [63:0] mem_alu_i,
  input  logic [63:0] mem_rs2_i,
  input  logic [7:0]  mem_mask_i,
  input  logic        flush,
  mem_access_unit_if.master dmem,
  output logic        mem_stall,
  output logic        misalign_o,
  output logic        wb_valid_o,
  output logic [63:0] wb_load_o
);

  mau_state_e  state;
  mau_state_e  state_nx;
  logic [63:0] ld_buf;
  logic [63:0] ld_data;
  logic [2:0]  f3;
  logic [2:0]  off;
  logic        is_ld;
  logic        is_st;
  logic        is_mem;
  logic        mis;
  logic        op_pending;
  logic        req;
  logic        cap;
  logic        unused_ok;

  assign f3     = mem_ins_i[14:12];
  assign off    = mem_alu_i[2:0];
  assign is_ld  = mem_decode_i[DEC_RE_BIT];
  assign is_st  = mem_decode_i[DEC_WE_BIT];
  assign is_mem = is_ld | is_st;
  assign mis    = mem_valid_i & is_mem
                & misaligned(f3, off);

  assign op_pending = mem_valid_i & is_mem
                    & ~mis & ~flush;

  assign unused_ok = ^{mem_ins_i, mem_decode_i};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      ld_buf <= '0;
    end else begin
      state <= state_nx;
      if (cap) ld_buf <= dmem.rsp_data;
    end
  end

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    cap      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req = op_pending;
        if (req && dmem.req_ready)
          state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        // A flushed op's response is dropped; if it
        // has not arrived yet, wait it out in DRAIN.
        if (flush) begin
          state_nx = dmem.rsp_valid ? ST_IDLE
                                    : ST_DRAIN;
        end else if (dmem.rsp_valid) begin
          state_nx = ST_DONE;
          cap      = 1'b1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      ST_DRAIN: begin
        if (dmem.rsp_valid) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  mem_load_align u_align (
    .ld_buf (ld_buf),
    .offset (off),
    .funct3 (f3),
    .data   (ld_data)
  );

  // Control outputs are forced low while rst is held so
  // the bus goes quiet without waiting for a clock.
  assign dmem.req_valid = rst & req;
  assign dmem.we    = rst & is_st;
  assign dmem.addr  = rst ? {mem_alu_i[63:3], 3'b000}
                          : '0;
  assign dmem.wdata = rst ? mem_rs2_i << {off, 3'b000}
                          : '0;
  assign dmem.wmask = rst ? mem_mask_i << off : '0;

  // A new op arriving in DRAIN is already covered here.
  assign mem_stall  = rst & op_pending
                    & (state != ST_DONE);
  assign misalign_o = rst & mis;
  assign wb_valid_o = rst & ((state == ST_DONE)
                    | (mem_valid_i & ~is_mem & ~flush));
  assign wb_load_o  = (rst && state == ST_DONE
                    && is_ld && !is_st) ? ld_data : '0;

endmodule
